// File: rtl/text_console_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : text_console_writer
// Description : Character-cell text console. Renders printable bytes from an
//               external synchronous font ROM into a 1-bit framebuffer one
//               pixel per cycle, and handles LF, CR, BS and FF control codes
//               with optional blanking of each newly entered row.
// Revision    : 1.0 - initial release
// ============================================================================
module text_console_writer #(
    parameter int CHAR_W     = 8,
    parameter int CHAR_H     = 8,
    parameter int COLS       = 100,
    parameter int ROWS       = 75,
    parameter int WRAP_CLEAR = 1,
    localparam int XW  = $clog2(COLS * CHAR_W),
    localparam int YW  = $clog2(ROWS * CHAR_H),
    localparam int CW  = (COLS > 1)   ? $clog2(COLS)   : 1,
    localparam int RW  = (ROWS > 1)   ? $clog2(ROWS)   : 1,
    localparam int FRW = (CHAR_H > 1) ? $clog2(CHAR_H) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    output logic              char_ready,
    output logic              busy,
    output logic [7:0]        font_char,
    output logic [FRW-1:0]    font_row,
    input  logic [CHAR_W-1:0] font_data,
    output logic              fb_we,
    output logic [XW-1:0]     fb_x,
    output logic [YW-1:0]     fb_y,
    output logic              fb_data,
    output logic [CW-1:0]     cursor_col,
    output logic [RW-1:0]     cursor_row
);

    localparam int PW = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;

    localparam logic [XW-1:0]  c_x_last   = XW'(COLS * CHAR_W - 1);
    localparam logic [YW-1:0]  c_y_last   = YW'(ROWS * CHAR_H - 1);
    localparam logic [CW-1:0]  c_col_last = CW'(COLS - 1);
    localparam logic [RW-1:0]  c_row_last = RW'(ROWS - 1);
    localparam logic [PW-1:0]  c_pix_last = PW'(CHAR_W - 1);
    localparam logic [FRW-1:0] c_sub_last = FRW'(CHAR_H - 1);

    localparam logic [7:0] c_bs = 8'h08;
    localparam logic [7:0] c_lf = 8'h0A;
    localparam logic [7:0] c_ff = 8'h0C;
    localparam logic [7:0] c_cr = 8'h0D;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAW  = 3'd2,
        S_ERASE = 3'd3,
        S_FILL  = 3'd4
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_col;       // cell committed to the cursor when the op ends
    logic [RW-1:0]     r_row;
    logic [PW-1:0]     r_pix;       // pixel index within a glyph row
    logic [FRW-1:0]    r_sub;       // glyph row index
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic [YW-1:0]     r_y_end;     // last raster line of the current fill
    logic [CHAR_W-1:0] r_glyph;
    logic              r_blank_en;  // ERASE writes pixels; clear = one-cycle cursor-only op

    logic [RW-1:0]     w_down_row;
    logic              w_col_wrap;
    logic [CW-1:0]     w_nxt_col;
    logic [RW-1:0]     w_nxt_row;
    logic [CW-1:0]     w_bs_col;
    logic [RW-1:0]     w_bs_row;
    logic [XW-1:0]     w_cur_x;
    logic [YW-1:0]     w_cur_y;
    logic [XW-1:0]     w_bs_x;
    logic [YW-1:0]     w_bs_y;
    logic [XW-1:0]     w_tgt_x;
    logic [YW-1:0]     w_down_y0;
    logic [PW-1:0]     w_bit_idx;
    logic              w_printable;
    logic              w_at_home;

    // Cursor arithmetic: next cell, row below, previous cell and their pixel origins
    always_comb begin
        w_down_row  = (cursor_row == c_row_last) ? '0 : cursor_row + 1'b1;
        w_col_wrap  = (cursor_col == c_col_last);
        w_nxt_col   = w_col_wrap ? '0 : cursor_col + 1'b1;
        w_nxt_row   = w_col_wrap ? w_down_row : cursor_row;
        w_bs_col    = (cursor_col != '0) ? cursor_col - 1'b1 : c_col_last;
        w_bs_row    = (cursor_col != '0) ? cursor_row : cursor_row - 1'b1;
        w_cur_x     = XW'(cursor_col) * XW'(CHAR_W);
        w_cur_y     = YW'(cursor_row) * YW'(CHAR_H);
        w_bs_x      = XW'(w_bs_col) * XW'(CHAR_W);
        w_bs_y      = YW'(w_bs_row) * YW'(CHAR_H);
        w_tgt_x     = XW'(r_col) * XW'(CHAR_W);
        w_down_y0   = YW'(w_down_row) * YW'(CHAR_H);
        w_bit_idx   = c_pix_last - r_pix;
        w_printable = (char_data >= 8'h20) && (char_data <= 8'h7E);
        w_at_home   = (cursor_col == '0) && (cursor_row == '0);
    end

    // The ROM row for pixel 0 arrives in the first DRAW cycle, so that pixel
    // is taken straight from the ROM and the rest from the latched copy.
    always_comb begin
        char_ready = (r_state == S_IDLE);
        busy       = (r_state != S_IDLE);
        fb_we      = (r_state == S_DRAW) || (r_state == S_FILL) ||
                     ((r_state == S_ERASE) && r_blank_en);
        fb_x       = r_x;
        fb_y       = r_y;
        fb_data    = 1'b0;
        if (r_state == S_DRAW) begin
            fb_data = (r_pix == '0) ? font_data[CHAR_W-1] : r_glyph[w_bit_idx];
        end
    end

    // Command decode, render/erase/fill sequencing and cursor update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_col      <= '0;
            r_row      <= '0;
            r_pix      <= '0;
            r_sub      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_y_end    <= '0;
            r_glyph    <= '0;
            r_blank_en <= 1'b0;
            font_char  <= '0;
            font_row   <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (char_valid) begin
                        r_pix <= '0;
                        r_sub <= '0;
                        if (w_printable) begin
                            font_char <= char_data;
                            font_row  <= '0;
                            r_x       <= w_cur_x;
                            r_y       <= w_cur_y;
                            r_state   <= S_FETCH;
                        end else if (char_data == c_lf) begin
                            r_col <= '0;
                            r_row <= w_down_row;
                            if (WRAP_CLEAR != 0) begin
                                cursor_col <= '0;
                                cursor_row <= w_down_row;
                                r_x        <= '0;
                                r_y        <= w_down_y0;
                                r_y_end    <= w_down_y0 + YW'(CHAR_H - 1);
                                r_state    <= S_FILL;
                            end else begin
                                r_blank_en <= 1'b0;
                                r_state    <= S_ERASE;
                            end
                        end else if (char_data == c_cr) begin
                            r_col      <= '0;
                            r_row      <= cursor_row;
                            r_blank_en <= 1'b0;
                            r_state    <= S_ERASE;
                        end else if (char_data == c_bs) begin
                            if (w_at_home) begin
                                r_col      <= cursor_col;
                                r_row      <= cursor_row;
                                r_blank_en <= 1'b0;
                            end else begin
                                r_col      <= w_bs_col;
                                r_row      <= w_bs_row;
                                r_x        <= w_bs_x;
                                r_y        <= w_bs_y;
                                r_blank_en <= 1'b1;
                            end
                            r_state <= S_ERASE;
                        end else if (char_data == c_ff) begin
                            r_col   <= '0;
                            r_row   <= '0;
                            r_x     <= '0;
                            r_y     <= '0;
                            r_y_end <= c_y_last;
                            r_state <= S_FILL;
                        end
                    end
                end

                S_FETCH: begin
                    r_pix   <= '0;
                    r_state <= S_DRAW;
                end

                S_DRAW: begin
                    if (r_pix == '0) begin
                        r_glyph <= font_data;
                    end
                    r_x   <= r_x + 1'b1;
                    r_pix <= r_pix + 1'b1;
                    if (r_pix == c_pix_last) begin
                        if (r_sub == c_sub_last) begin
                            cursor_col <= w_nxt_col;
                            cursor_row <= w_nxt_row;
                            if ((WRAP_CLEAR != 0) && w_col_wrap) begin
                                r_col   <= w_nxt_col;
                                r_row   <= w_nxt_row;
                                r_x     <= '0;
                                r_y     <= w_down_y0;
                                r_y_end <= w_down_y0 + YW'(CHAR_H - 1);
                                r_state <= S_FILL;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_sub    <= r_sub + 1'b1;
                            font_row <= r_sub + 1'b1;
                            r_pix    <= '0;
                            r_x      <= w_cur_x;
                            r_y      <= r_y + 1'b1;
                            r_state  <= S_FETCH;
                        end
                    end
                end

                S_ERASE: begin
                    if (!r_blank_en) begin
                        cursor_col <= r_col;
                        cursor_row <= r_row;
                        r_state    <= S_IDLE;
                    end else begin
                        r_x   <= r_x + 1'b1;
                        r_pix <= r_pix + 1'b1;
                        if (r_pix == c_pix_last) begin
                            r_pix <= '0;
                            r_x   <= w_tgt_x;
                            r_y   <= r_y + 1'b1;
                            r_sub <= r_sub + 1'b1;
                            if (r_sub == c_sub_last) begin
                                cursor_col <= r_col;
                                cursor_row <= r_row;
                                r_state    <= S_IDLE;
                            end
                        end
                    end
                end

                S_FILL: begin
                    if (r_x == c_x_last) begin
                        r_x <= '0;
                        r_y <= r_y + 1'b1;
                        if (r_y == r_y_end) begin
                            cursor_col <= r_col;
                            cursor_row <= r_row;
                            r_state    <= S_IDLE;
                        end
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_text_console_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_text_console_writer
// Description : Scoreboard bench for text_console_writer. A default-geometry
//               instance (WRAP_CLEAR=1) and a small instance (4x3 cells,
//               WRAP_CLEAR=0) share clock and reset; expected pixel writes
//               are queued from a behavioural console model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_console_writer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // default instance
    logic       a_valid, a_ready, a_busy, a_we, a_data_o;
    logic [7:0] a_data, a_fchar, a_fdata;
    logic [2:0] a_frow;
    logic [9:0] a_x, a_y;
    logic [6:0] a_col;
    logic [6:0] a_row;

    // small instance
    logic       b_valid, b_ready, b_busy, b_we, b_data_o;
    logic [7:0] b_data, b_fchar, b_fdata;
    logic [2:0] b_frow;
    logic [4:0] b_x, b_y;
    logic [1:0] b_col;
    logic [1:0] b_row;

    text_console_writer u_dut_a (
        .clk(clk), .rst_n(rst_n), .char_valid(a_valid), .char_data(a_data),
        .char_ready(a_ready), .busy(a_busy), .font_char(a_fchar), .font_row(a_frow),
        .font_data(a_fdata), .fb_we(a_we), .fb_x(a_x), .fb_y(a_y), .fb_data(a_data_o),
        .cursor_col(a_col), .cursor_row(a_row)
    );

    text_console_writer #(.CHAR_W(8), .CHAR_H(8), .COLS(4), .ROWS(3), .WRAP_CLEAR(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .char_valid(b_valid), .char_data(b_data),
        .char_ready(b_ready), .busy(b_busy), .font_char(b_fchar), .font_row(b_frow),
        .font_data(b_fdata), .fb_we(b_we), .fb_x(b_x), .fb_y(b_y), .fb_data(b_data_o),
        .cursor_col(b_col), .cursor_row(b_row)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int wr_a = 0, wr_b = 0;
    logic [32:0] last_b;
    logic [32:0] q_a [$];
    logic [32:0] q_b [$];
    int m_col [2];
    int m_row [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Font ROM contents: blank for space, a scrambled pattern otherwise
    function automatic logic [7:0] rom(input logic [7:0] ch, input logic [2:0] r);
        logic [7:0] v;
        v = (ch * 8'd29) ^ ({5'b0, r} * 8'd53) ^ 8'h3C;
        return (ch == 8'h20) ? 8'h00 : v;
    endfunction

    initial begin
        a_fdata = '0;
        b_fdata = '0;
    end
    always @(posedge clk) begin
        a_fdata <= rom(a_fchar, a_frow);
        b_fdata <= rom(b_fchar, b_frow);
    end

    function automatic logic [32:0] pk(input int x, input int y, input logic d);
        return {x[15:0], y[15:0], d};
    endfunction

    task automatic push(input int sel, input logic [32:0] v);
        if (sel == 0) q_a.push_back(v); else q_b.push_back(v);
    endtask

    // Behavioural console: queues the pixel writes a byte should cause
    task automatic model_cmd(input int sel, input logic [7:0] ch);
        int cols, rows, col, row;
        bit wc, adv;
        logic [7:0] g;
        cols = (sel == 0) ? 100 : 4;
        rows = (sel == 0) ? 75 : 3;
        wc   = (sel == 0);
        col  = m_col[sel];
        row  = m_row[sel];
        adv  = 1'b0;
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            for (int r = 0; r < 8; r++) begin
                g = rom(ch, 3'(r));
                for (int i = 0; i < 8; i++) push(sel, pk(col*8 + i, row*8 + r, g[7-i]));
            end
            if (col == cols - 1) begin col = 0; row = (row + 1) % rows; adv = 1'b1; end
            else col++;
        end else if (ch == 8'h0A) begin
            col = 0; row = (row + 1) % rows; adv = 1'b1;
        end else if (ch == 8'h0D) begin
            col = 0;
        end else if (ch == 8'h08) begin
            if (col > 0 || row > 0) begin
                if (col > 0) col--;
                else begin row--; col = cols - 1; end
                for (int r = 0; r < 8; r++)
                    for (int i = 0; i < 8; i++) push(sel, pk(col*8 + i, row*8 + r, 1'b0));
            end
        end else if (ch == 8'h0C) begin
            for (int y = 0; y < rows*8; y++)
                for (int x = 0; x < cols*8; x++) push(sel, pk(x, y, 1'b0));
            col = 0; row = 0;
        end
        if (adv && wc)
            for (int y = row*8; y < row*8 + 8; y++)
                for (int x = 0; x < cols*8; x++) push(sel, pk(x, y, 1'b0));
        m_col[sel] = col;
        m_row[sel] = row;
    endtask

    // Scoreboard monitors, sampled on the falling edge
    always @(negedge clk) begin
        if (a_we) begin
            wr_a++;
            if (q_a.size() == 0) check("a_unexpected_we", a_we, 1'b0);
            else check("a_pixel", pk(int'(a_x), int'(a_y), a_data_o), q_a.pop_front());
        end
        if (b_we) begin
            wr_b++;
            last_b = pk(int'(b_x), int'(b_y), b_data_o);
            if (q_b.size() == 0) check("b_unexpected_we", b_we, 1'b0);
            else check("b_pixel", last_b, q_b.pop_front());
        end
    end

    function automatic logic rdy(input int sel);
        return (sel == 0) ? a_ready : b_ready;
    endfunction

    function automatic logic bsy(input int sel);
        return (sel == 0) ? a_busy : b_busy;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] d);
        if (sel == 0) begin a_valid = v; a_data = d; end
        else begin b_valid = v; b_data = d; end
    endtask

    // Offer a byte, wait for its accept edge, return with valid still high
    task automatic offer(input int sel, input logic [7:0] ch);
        int g;
        drive(sel, 1'b1, ch);
        g = 0;
        while (!rdy(sel) && g < 20000) begin @(posedge clk); #1; g++; end
        if (g >= 20000) check("ready_timeout", rdy(sel), 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic send(input int sel, input logic [7:0] ch, output int nbusy);
        model_cmd(sel, ch);
        offer(sel, ch);
        drive(sel, 1'b0, 8'h00);
        nbusy = 0;
        while (bsy(sel) && nbusy < 20000) begin @(posedge clk); #1; nbusy++; end
        if (nbusy >= 20000) check("busy_timeout", bsy(sel), 1'b0);
        check((sel == 0) ? "a_queue_drained" : "b_queue_drained",
              (sel == 0) ? q_a.size() : q_b.size(), 0);
    endtask

    task automatic check_cur(input int sel, input string tag);
        if (sel == 0) check(tag, {32'(a_col), 32'(a_row)}, {32'(m_col[0]), 32'(m_row[0])});
        else          check(tag, {32'(b_col), 32'(b_row)}, {32'(m_col[1]), 32'(m_row[1])});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb, base, g;
        m_col[0] = 0; m_row[0] = 0; m_col[1] = 0; m_row[1] = 0;
        a_valid = 1'b0; a_data = '0; b_valid = 1'b0; b_data = '0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {a_we, a_x, a_y, a_data_o, a_fchar, a_frow, a_col, a_row, a_busy}, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_ready", a_ready, 1'b1);

        // 'A' at (0,0)
        base = wr_a;
        send(0, 8'h41, nb);
        check("A_busy_cycles", nb, 72);
        check("A_writes", wr_a - base, 64);
        check_cur(0, "A_cursor");
        check("A_ready_after", a_ready, 1'b1);

        // reset at pixel 30 of a render at (1,0)
        model_cmd(0, 8'h5A);
        base = wr_a;
        offer(0, 8'h5A);
        drive(0, 1'b0, 8'h00);
        g = 0;
        while ((wr_a - base) < 30 && g < 200) begin @(posedge clk); #1; g++; end
        check("rst_px30_reached", wr_a - base, 30);
        check("rst_px30_we_high", a_we, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_we_same_cycle", a_we, 1'b0);
        q_a.delete();
        m_col[0] = 0; m_row[0] = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_release_ready", a_ready, 1'b1);
        check_cur(0, "rst_release_cursor");
        repeat (20) @(posedge clk);
        #1;
        check("rst_no_stray_writes", wr_a - base, 30);

        // backspace at (0,0) and an ignored control byte
        base = wr_a;
        send(0, 8'h08, nb);
        check("bs_home_busy", nb, 1);
        check("bs_home_writes", wr_a - base, 0);
        check_cur(0, "bs_home_cursor");
        send(0, 8'h01, nb);
        check("other_byte_busy", nb, 0);
        check_cur(0, "other_byte_cursor");

        // four line feeds, each blanking the row entered
        for (int k = 1; k <= 4; k++) begin
            base = wr_a;
            send(0, 8'h0A, nb);
            check("lf_clear_busy", nb, 6400);
            check("lf_clear_writes", wr_a - base, 6400);
            check_cur(0, "lf_cursor");
        end

        // backspace across a row boundary: (0,4) -> (99,3)
        base = wr_a;
        send(0, 8'h08, nb);
        check("bs_wrap_busy", nb, 64);
        check("bs_wrap_writes", wr_a - base, 64);
        check_cur(0, "bs_wrap_cursor");

        // 'B' in the last column: draw, wrap to (0,4), blank row 4
        base = wr_a;
        send(0, 8'h42, nb);
        check("B_wrap_busy", nb, 72 + 6400);
        check("B_wrap_writes", wr_a - base, 64 + 6400);
        check_cur(0, "B_wrap_cursor");

        // LF to (0,5), backspace to (99,4)
        send(0, 8'h0A, nb);
        base = wr_a;
        send(0, 8'h08, nb);
        check("bs_row5_writes", wr_a - base, 64);
        check_cur(0, "bs_row5_cursor");

        // CR then a space rendered as a blank glyph
        base = wr_a;
        send(0, 8'h0D, nb);
        check("cr_busy", nb, 1);
        check("cr_writes", wr_a - base, 0);
        check_cur(0, "cr_cursor");
        send(0, 8'h20, nb);
        check("space_writes", wr_a - base, 64);
        check_cur(0, "space_cursor");

        // small instance, no row blanking
        base = wr_b;
        send(1, 8'h43, nb);
        check("b_C_writes", wr_b - base, 64);
        check_cur(1, "b_C_cursor");
        send(1, 8'h0A, nb);
        send(1, 8'h0A, nb);
        check_cur(1, "b_lf_row2_cursor");
        base = wr_b;
        send(1, 8'h0A, nb);
        check("b_lf_last_row_busy", nb, 1);
        check("b_lf_last_row_writes", wr_b - base, 0);
        check_cur(1, "b_lf_last_row_cursor");
        send(1, 8'h44, nb);

        // form feed with the next byte held on char_valid throughout
        model_cmd(1, 8'h0C);
        model_cmd(1, 8'h45);
        base = wr_b;
        offer(1, 8'h0C);
        drive(1, 1'b1, 8'h45);
        nb = 0;
        while (!b_ready && nb < 5000) begin @(posedge clk); #1; nb++; end
        check("b_ff_busy", nb, 32 * 24);
        check("b_ff_writes", wr_b - base, 32 * 24);
        check("b_ff_last_pixel", last_b, pk(31, 23, 1'b0));
        check("b_ff_cursor", {32'(b_col), 32'(b_row)}, 64'h0);
        @(posedge clk); #1;
        drive(1, 1'b0, 8'h00);
        nb = 0;
        while (b_busy && nb < 5000) begin @(posedge clk); #1; nb++; end
        check("b_held_char_busy", nb, 72);
        check("b_held_char_writes", wr_b - base, 32 * 24 + 64);
        check("b_held_queue_drained", q_b.size(), 0);
        check_cur(1, "b_held_char_cursor");

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
